// File: rtl/adaptive_binarize.sv
// adaptive_binarize: local-mean adaptive threshold stage.
// Each pixel becomes white (8'hFF) when 9*centre + 9*THR_C > sum of its 3x3 window.
// Otherwise it becomes black (8'h00).
// The window is built from the incoming pixel (bottom-right tap), two line buffers and
// 2-deep column shift registers. Its centre is (row-1, col-1).
// Stream semantics: there is no backpressure. gray_de qualifies gray_data on every cycle,
// and bina_de qualifies bina_data on every cycle, exactly 4 clk later.
module adaptive_binarize #(
  parameter logic [11:0] H_DISP = 12'd640,
  parameter logic [11:0] V_DISP = 12'd480,
  parameter logic [7:0]  THR_C  = 8'd5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gray_de,
  input  logic       gray_hsync,
  input  logic       gray_vsync,
  input  logic [7:0] gray_data,
  output logic       bina_de,
  output logic       bina_hsync,
  output logic       bina_vsync,
  output logic [7:0] bina_data
);

  localparam int          AW   = $clog2(H_DISP);
  localparam logic [12:0] THR9 = 13'd9 * {5'd0, THR_C};

  // Edge detection and position counters
  logic        de_q, vs_q;
  logic        de_fall, vs_rise;
  logic [11:0] col_cnt, row_cnt;
  logic        col_ovf, row_ovf;

  assign de_fall = de_q & ~gray_de;
  assign vs_rise = gray_vsync & ~vs_q;

  // Line buffers (contents are never cleared; border masking hides stale data)
  logic [7:0]    lb1 [0:H_DISP-1];
  logic [7:0]    lb2 [0:H_DISP-1];
  logic [AW-1:0] lb_addr;
  logic [7:0]    lb1_rd, lb2_rd;
  logic          lb_we;

  assign lb_addr = col_cnt[AW-1:0];
  assign lb1_rd  = lb1[lb_addr];
  assign lb2_rd  = lb2[lb_addr];
  assign lb_we   = gray_de & ~col_ovf & ~row_ovf;

  // Border-masked new column taps
  logic [7:0] tap_r1, tap_r2;
  logic       col1_ok, col2_ok;

  assign tap_r1  = (row_cnt >= 12'd1) ? lb1_rd : 8'd0;
  assign tap_r2  = (row_cnt >= 12'd2) ? lb2_rd : 8'd0;
  assign col1_ok = (col_cnt >= 12'd1);
  assign col2_ok = (col_cnt >= 12'd2);

  // Pipeline registers
  logic [7:0]  w11, w12, w13, w21, w22, w23, w31, w32, w33;
  logic [9:0]  rs1, rs2, rs3;
  logic [7:0]  ctr_s2;
  logic [11:0] sum9;
  logic [12:0] lhs;
  logic [2:0]  de_p, hs_p, vs_p;

  // Column/row counters with saturation; the overflow flags block storing excess pixels/lines
  always_ff @(posedge clk) begin
    if (rst) begin
      de_q    <= 1'b0;
      vs_q    <= 1'b0;
      col_cnt <= 12'd0;
      row_cnt <= 12'd0;
      col_ovf <= 1'b0;
      row_ovf <= 1'b0;
    end else begin
      de_q <= gray_de;
      vs_q <= gray_vsync;
      if (de_fall) begin
        col_cnt <= 12'd0;
        col_ovf <= 1'b0;
      end else if (gray_de) begin
        if (col_cnt == H_DISP - 12'd1) col_ovf <= 1'b1;
        else                           col_cnt <= col_cnt + 12'd1;
      end
      if (vs_rise) begin
        row_cnt <= 12'd0;
        row_ovf <= 1'b0;
      end else if (de_fall) begin
        if (row_cnt == V_DISP - 12'd1) row_ovf <= 1'b1;
        else                           row_cnt <= row_cnt + 12'd1;
      end
    end
  end

  // Line buffer write: lb1 takes the new pixel, lb2 takes what lb1 held (read-before-write)
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb1[lb_addr] <= gray_data;
      lb2[lb_addr] <= lb1_rd;
    end
  end

  // S1: shift the 3x3 window one column, zeroing taps that fall outside the frame
  always_ff @(posedge clk) begin
    if (rst) begin
      {w11, w12, w13, w21, w22, w23, w31, w32, w33} <= '0;
      de_p[0] <= 1'b0;
      hs_p[0] <= 1'b0;
      vs_p[0] <= 1'b0;
    end else begin
      w13 <= tap_r2;
      w12 <= col1_ok ? w13 : 8'd0;
      w11 <= col2_ok ? w12 : 8'd0;
      w23 <= tap_r1;
      w22 <= col1_ok ? w23 : 8'd0;
      w21 <= col2_ok ? w22 : 8'd0;
      w33 <= gray_data;
      w32 <= col1_ok ? w33 : 8'd0;
      w31 <= col2_ok ? w32 : 8'd0;
      de_p[0] <= gray_de;
      hs_p[0] <= gray_hsync;
      vs_p[0] <= gray_vsync;
    end
  end

  // S2: per-row sums and centre capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1     <= 10'd0;
      rs2     <= 10'd0;
      rs3     <= 10'd0;
      ctr_s2  <= 8'd0;
      de_p[1] <= 1'b0;
      hs_p[1] <= 1'b0;
      vs_p[1] <= 1'b0;
    end else begin
      rs1     <= {2'd0, w11} + {2'd0, w12} + {2'd0, w13};
      rs2     <= {2'd0, w21} + {2'd0, w22} + {2'd0, w23};
      rs3     <= {2'd0, w31} + {2'd0, w32} + {2'd0, w33};
      ctr_s2  <= w22;
      de_p[1] <= de_p[0];
      hs_p[1] <= hs_p[0];
      vs_p[1] <= vs_p[0];
    end
  end

  // S3: window total and scaled centre-plus-offset (compare without division)
  always_ff @(posedge clk) begin
    if (rst) begin
      sum9    <= 12'd0;
      lhs     <= 13'd0;
      de_p[2] <= 1'b0;
      hs_p[2] <= 1'b0;
      vs_p[2] <= 1'b0;
    end else begin
      sum9    <= {2'd0, rs1} + {2'd0, rs2} + {2'd0, rs3};
      lhs     <= ({5'd0, ctr_s2} * 13'd9) + THR9;
      de_p[2] <= de_p[1];
      hs_p[2] <= hs_p[1];
      vs_p[2] <= vs_p[1];
    end
  end

  // S4: threshold decision; data forced black outside active pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      bina_de    <= 1'b0;
      bina_hsync <= 1'b0;
      bina_vsync <= 1'b0;
      bina_data  <= 8'h00;
    end else begin
      bina_de    <= de_p[2];
      bina_hsync <= hs_p[2];
      bina_vsync <= vs_p[2];
      bina_data  <= (de_p[2] && (lhs > {1'b0, sum9})) ? 8'hFF : 8'h00;
    end
  end

endmodule

// File: tb/tb_adaptive_binarize.sv
// tb_adaptive_binarize: frame-level reference model for adaptive_binarize.
// Expected output per pixel is computed from the whole input image held in an array.
module tb_adaptive_binarize;

  localparam int THR = 5;

  logic       clk;
  logic       rst;
  logic       gray_de, gray_hsync, gray_vsync;
  logic [7:0] gray_data;
  logic       bina_de, bina_hsync, bina_vsync;
  logic [7:0] bina_data;

  int n_tests;
  int n_fail;
  string phase;

  // expected {de, hsync, vsync, data}, one entry per driven cycle
  logic [10:0] exp_q[$];

  int img [0:15][0:15];

  adaptive_binarize #(
    .H_DISP(12'd640),
    .V_DISP(12'd480),
    .THR_C (8'd5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .gray_de   (gray_de),
    .gray_hsync(gray_hsync),
    .gray_vsync(gray_vsync),
    .gray_data (gray_data),
    .bina_de   (bina_de),
    .bina_hsync(bina_hsync),
    .bina_vsync(bina_vsync),
    .bina_data (bina_data)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s.%s: got %02h expected %02h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  // Window of rows r-2..r, cols c-2..c with anything off the top/left reading 0.
  // Row 0 and column 0 have a zero centre, so they come out black on non-zero content.
  function automatic logic [7:0] exp_pix(input int r, input int c);
    int sum;
    int ctr;
    sum = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if (r - dr >= 0 && c - dc >= 0) sum += img[r-dr][c-dc];
    ctr = (r >= 1 && c >= 1) ? img[r-1][c-1] : 0;
    return (9 * ctr + 9 * THR > sum) ? 8'hFF : 8'h00;
  endfunction

  // one clock cycle: drive, record expectation, compare the entry from 4 cycles ago
  task automatic step(input logic r, input logic de, input logic hs, input logic vs,
                      input logic [7:0] d, input logic [7:0] ed);
    logic [10:0] e;
    @(posedge clk);
    #1;
    rst        = r;
    gray_de    = de;
    gray_hsync = hs;
    gray_vsync = vs;
    gray_data  = d;
    exp_q.push_back({de, hs, vs, (de ? ed : 8'h00)});
    @(negedge clk);
    if (exp_q.size() > 4) begin
      e = exp_q.pop_front();
      check_val("de",   {7'd0, bina_de},    {7'd0, e[10]});
      check_val("hs",   {7'd0, bina_hsync}, {7'd0, e[9]});
      check_val("vs",   {7'd0, bina_vsync}, {7'd0, e[8]});
      check_val("data", bina_data,          e[7:0]);
    end
    if (r) begin
      foreach (exp_q[k]) exp_q[k] = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // send img[0..nr-1][0..nc-1]; reset is pulsed in place of pixel (rr,rc) if given
  task automatic send_frame(input int nr, input int nc, input int rr, input int rc);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    idle(2);
    for (int r = 0; r < nr; r++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
      idle(1);
      for (int c = 0; c < nc; c++) begin
        if (r == rr && c == rc) begin
          step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
          return;
        end
        step(1'b0, 1'b1, 1'b0, 1'b0, img[r][c][7:0], exp_pix(r, c));
      end
      idle(3);
    end
    idle(2);
  endtask

  task automatic fill_flat(input int v);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) img[r][c] = v;
  endtask

  // stimulus
  initial begin
    int nr, nc;
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    gray_de    = 1'b0;
    gray_hsync = 1'b0;
    gray_vsync = 1'b0;
    gray_data  = 8'h00;
    repeat (3) @(posedge clk);

    phase = "reset";
    for (int i = 0; i < 4; i++) exp_q.push_back('0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);

    phase = "flat";
    fill_flat(100);
    send_frame(8, 8, -1, -1);

    phase = "bright";
    fill_flat(100);
    img[3][3] = 200;
    send_frame(8, 8, -1, -1);

    phase = "dark";
    fill_flat(100);
    img[3][3] = 0;
    send_frame(8, 8, -1, -1);

    phase = "leak_white";
    fill_flat(255);
    send_frame(8, 8, -1, -1);
    phase = "leak_black";
    fill_flat(0);
    send_frame(8, 8, -1, -1);

    phase = "rst_mid";
    fill_flat(100);
    send_frame(8, 8, 3, 5);
    idle(6);
    phase = "after_rst";
    send_frame(8, 8, -1, -1);

    for (int k = 0; k < 6; k++) begin
      phase = $sformatf("rand%0d", k);
      nr = $urandom_range(3, 10);
      nc = $urandom_range(3, 12);
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          img[r][c] = (k % 2 == 0) ? int'($urandom_range(0, 255))
                                   : 90 + int'($urandom_range(0, 20));
      send_frame(nr, nc, -1, -1);
    end

    phase = "drain";
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
